// File: rtl/weight_loader.sv
// Weight-port front end for the convolution core: streams WEIGHT_COUNT words to
// sequential weight addresses, verifies a trailing checksum, and gates pixel traffic.
module weight_loader #(
    parameter int WEIGHT_COUNT = 77,
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 32,
    parameter int PIX_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] weight_wr_data,
    output logic [ADDR_W-1:0] weight_wr_addr,
    output logic              weight_wr_en,
    output logic              busy,
    output logic              load_done,
    output logic              load_err,
    input  logic [PIX_W-1:0]  pix_in_data,
    input  logic              pix_in_valid,
    output logic [PIX_W-1:0]  pix_out_data,
    output logic              pix_out_valid
);

    localparam int CNT_W = $clog2(WEIGHT_COUNT);

    typedef enum logic [2:0] {IDLE, LOAD, CHECK, DONE, ERR} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] sum;
    logic              accept;
    logic              take_start;
    logic              last_word;

    assign s_ready    = (state == LOAD) || (state == CHECK);
    assign busy       = s_ready;
    assign load_done  = (state == DONE);
    assign load_err   = (state == ERR);
    assign accept     = s_valid & s_ready;
    assign take_start = start & ((state == IDLE) || (state == DONE) || (state == ERR));
    assign last_word  = (cnt == CNT_W'(WEIGHT_COUNT - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE, ERR: if (take_start) state_nxt = LOAD;
            LOAD:            if (accept && last_word) state_nxt = CHECK;
            CHECK:           if (accept) state_nxt = (s_data == sum) ? DONE : ERR;
            default:         state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt            <= '0;
            sum            <= '0;
            weight_wr_en   <= 1'b0;
            weight_wr_addr <= '0;
            weight_wr_data <= '0;
            pix_out_valid  <= 1'b0;
            pix_out_data   <= '0;
        end else begin
            weight_wr_en <= 1'b0;
            if (take_start) begin
                cnt <= '0;
                sum <= '0;
            end
            if (state == LOAD && accept) begin
                weight_wr_en   <= 1'b1;
                weight_wr_addr <= ADDR_W'(cnt);
                weight_wr_data <= s_data;
                cnt            <= cnt + CNT_W'(1);
                sum            <= sum + s_data;
            end
            // A start sampled in DONE closes the gate in that same cycle.
            pix_out_valid <= pix_in_valid & (state == DONE) & ~start;
            if (pix_in_valid) pix_out_data <= pix_in_data;
        end
    end

endmodule

// File: tb/tb_weight_loader.sv
// Directed self-checking bench for weight_loader: nominal, bad-checksum, gapped,
// wrap-around, pixel gating, mid-load reset and reload-from-DONE scenarios.
module tb_weight_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] weight_wr_data;
    logic [31:0] weight_wr_addr;
    logic        weight_wr_en;
    logic        busy;
    logic        load_done;
    logic        load_err;
    logic [15:0] pix_in_data;
    logic        pix_in_valid;
    logic [15:0] pix_out_data;
    logic        pix_out_valid;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    weight_loader #(
        .WEIGHT_COUNT(77),
        .DATA_W(16),
        .ADDR_W(32),
        .PIX_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .s_data(s_data),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .weight_wr_data(weight_wr_data),
        .weight_wr_addr(weight_wr_addr),
        .weight_wr_en(weight_wr_en),
        .busy(busy),
        .load_done(load_done),
        .load_err(load_err),
        .pix_in_data(pix_in_data),
        .pix_in_valid(pix_in_valid),
        .pix_out_data(pix_out_data),
        .pix_out_valid(pix_out_valid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock with the given stream input; outputs sampled on the following negedge.
    task automatic beat(input logic [15:0] d, input logic v, input logic exp_wr,
                        input logic [31:0] exp_addr);
        s_data  = d;
        s_valid = v;
        @(posedge clk);
        @(negedge clk);
        s_valid = 1'b0;
        chk("wr_en", {31'b0, weight_wr_en}, {31'b0, exp_wr});
        if (exp_wr) begin
            chk("wr_addr", weight_wr_addr, exp_addr);
            chk("wr_data", {16'b0, weight_wr_data}, {16'b0, d});
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", {31'b0, busy}, 32'd1);
        chk("done_after_start", {31'b0, load_done}, 32'd0);
    endtask

    function automatic logic [15:0] word(input int mode, input int i);
        if (mode == 1) return 16'hFFFF;
        if (i < 72) return 16'h0001;
        if (i < 76) return 16'h000A;
        return 16'h0100;
    endfunction

    task automatic load_words(input int mode, input logic gapped, input logic [15:0] cks,
                              input logic exp_ok);
        for (int i = 0; i < 77; i++) begin
            if (gapped && (i % 2 == 1)) begin
                beat(16'hDEAD, 1'b0, 1'b0, 32'd0);
                beat(16'hBEEF, 1'b0, 1'b0, 32'd0);
            end
            chk("busy_load", {31'b0, busy}, 32'd1);
            beat(word(mode, i), 1'b1, 1'b1, i);
        end
        chk("busy_check", {31'b0, busy}, 32'd1);
        chk("ready_check", {31'b0, s_ready}, 32'd1);
        beat(cks, 1'b1, 1'b0, 32'd0);
        chk("busy_end", {31'b0, busy}, 32'd0);
        chk("ready_end", {31'b0, s_ready}, 32'd0);
        chk("load_done", {31'b0, load_done}, {31'b0, exp_ok});
        chk("load_err", {31'b0, load_err}, {31'b0, ~exp_ok});
    endtask

    task automatic pix(input logic v, input logic [15:0] d, input logic exp_v,
                       input logic [15:0] exp_d);
        pix_in_valid = v;
        pix_in_data  = d;
        @(posedge clk);
        @(negedge clk);
        pix_in_valid = 1'b0;
        chk("pix_valid", {31'b0, pix_out_valid}, {31'b0, exp_v});
        if (exp_v) chk("pix_data", {16'b0, pix_out_data}, {16'b0, exp_d});
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; s_data = '0; s_valid = 1'b0;
        pix_in_data = '0; pix_in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'b0, s_ready}, 32'd0);
        chk("rst_wr_en", {31'b0, weight_wr_en}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, load_done}, 32'd0);
        chk("rst_err", {31'b0, load_err}, 32'd0);
        chk("rst_pix_valid", {31'b0, pix_out_valid}, 32'd0);
        chk("rst_wr_addr", weight_wr_addr, 32'd0);
        chk("rst_wr_data", {16'b0, weight_wr_data}, 32'd0);
        chk("rst_pix_data", {16'b0, pix_out_data}, 32'd0);
        rst = 1'b0;

        // Pixels before any load are dropped.
        for (int i = 0; i < 25; i++) pix(1'b1, 16'd100, 1'b0, 16'd0);

        // start together with s_valid in IDLE: word is not accepted.
        start = 1'b1; s_valid = 1'b1; s_data = 16'h5555;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; s_valid = 1'b0;
        chk("idle_start_wr_en", {31'b0, weight_wr_en}, 32'd0);
        chk("idle_start_busy", {31'b0, busy}, 32'd1);
        load_words(0, 1'b0, 16'h0170, 1'b1);

        // Pixels after DONE pass with 1-cycle latency.
        for (int i = 0; i < 25; i++) pix(1'b1, 16'd100, 1'b1, 16'd100);
        pix(1'b0, 16'd7, 1'b0, 16'd0);
        chk("pix_data_hold", {16'b0, pix_out_data}, 32'd100);

        // Reload from DONE with pixel valid held high.
        pix_in_valid = 1'b1; pix_in_data = 16'd100;
        @(posedge clk);
        @(negedge clk);
        chk("reload_pix_before", {31'b0, pix_out_valid}, 32'd1);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("reload_pix_drop", {31'b0, pix_out_valid}, 32'd0);
        chk("reload_busy", {31'b0, busy}, 32'd1);
        chk("reload_done_low", {31'b0, load_done}, 32'd0);
        load_words(0, 1'b0, 16'h0170, 1'b1);
        chk("reload_pix_still_low", {31'b0, pix_out_valid}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("reload_pix_back", {31'b0, pix_out_valid}, 32'd1);
        pix_in_valid = 1'b0;
        @(negedge clk);

        // Bad checksum ends in ERR and keeps the pixel gate closed.
        do_start();
        load_words(0, 1'b0, 16'h0171, 1'b0);
        for (int i = 0; i < 5; i++) pix(1'b1, 16'd100, 1'b0, 16'd0);

        // Gapped stream.
        do_start();
        load_words(0, 1'b1, 16'h0170, 1'b1);

        // Checksum wrap: 77 x 0xFFFF sums to 0xFFB3.
        do_start();
        load_words(1, 1'b0, 16'hFFB3, 1'b1);

        // Reset after 40 words, then a clean reload from address 0.
        do_start();
        for (int i = 0; i < 40; i++) beat(word(0, i), 1'b1, 1'b1, i);
        rst = 1'b1; s_valid = 1'b1; s_data = 16'h0001;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; s_valid = 1'b0;
        chk("midrst_ready", {31'b0, s_ready}, 32'd0);
        chk("midrst_wr_en", {31'b0, weight_wr_en}, 32'd0);
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_done", {31'b0, load_done}, 32'd0);
        beat(16'h0001, 1'b1, 1'b0, 32'd0);
        do_start();
        load_words(0, 1'b0, 16'h0170, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
